// File: rtl/cycle_sequencer_if.sv
// Handshake bundle between microcode control and the M-cycle/T-state sequencer.
// The controller side is the master; the sequencer is the slave.
interface cycle_sequencer_if #(
  parameter int STEPS      = 4,
  parameter int MAX_CYCLES = 8
);
  logic                  ir_fetch;
  logic                  stall;
  logic                  halt_request;
  logic                  wake;
  logic [7:0]            bus_data;
  logic [STEPS-1:0]      cycle_step;
  logic [MAX_CYCLES-1:0] cycle_count;
  logic [7:0]            ir;
  logic                  fetch_active;
  logic                  instr_start;
  logic                  halted;
  logic                  overrun;

  modport master (
    output ir_fetch, stall, halt_request, wake, bus_data,
    input  cycle_step, cycle_count, ir, fetch_active, instr_start, halted, overrun
  );

  modport slave (
    input  ir_fetch, stall, halt_request, wake, bus_data,
    output cycle_step, cycle_count, ir, fetch_active, instr_start, halted, overrun
  );
endinterface

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle sequencer with overlapped IR fetch, HALT with wake, and stall freeze.
// All outputs are registered; the internal step keeps rotating in HALT to preserve M-cycle timing.
module cycle_sequencer #(
  parameter int STEPS      = 4,
  parameter int MAX_CYCLES = 8
) (
  input logic               clk,
  input logic               rst,
  cycle_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  localparam logic [STEPS-1:0]      STEP_FIRST  = STEPS'(1);
  localparam logic [MAX_CYCLES-1:0] COUNT_FIRST = MAX_CYCLES'(1);

  state_t                state_q, state_d;
  logic [STEPS-1:0]      step_q, step_d;
  logic [STEPS-1:0]      step_out_q;
  logic [MAX_CYCLES-1:0] count_q, count_d;
  logic [7:0]            ir_q, ir_d;
  logic                  overrun_q, overrun_d;
  logic                  wake_q, wake_d;
  logic                  latch;
  logic                  instr_start_q;
  logic                  fetch_active_q;
  logic                  halted_q;

  logic last_step;
  assign last_step = step_q[STEPS-1];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    count_d   = count_q;
    ir_d      = ir_q;
    overrun_d = overrun_q;
    wake_d    = wake_q;
    latch     = 1'b0;

    // Stall has priority over everything but reset: nothing moves, nothing latches.
    if (!bus.stall) begin
      step_d = {step_q[STEPS-2:0], step_q[STEPS-1]};
      unique case (state_q)
        FETCH: begin
          if (last_step) begin
            latch   = 1'b1;
            state_d = EXEC;
            count_d = COUNT_FIRST;
          end
        end
        EXEC: begin
          if (last_step) begin
            if (bus.ir_fetch && bus.halt_request) begin
              state_d = HALT;
              count_d = '0;
            end else if (bus.ir_fetch) begin
              latch   = 1'b1;
              count_d = COUNT_FIRST;
            end else begin
              // Rotating left wraps the top bit back to 0x01; that wrap is an overrun.
              count_d   = {count_q[MAX_CYCLES-2:0], count_q[MAX_CYCLES-1]};
              overrun_d = overrun_q | count_q[MAX_CYCLES-1];
            end
          end
        end
        HALT: begin
          wake_d = wake_q | bus.wake;
          if (last_step && (wake_q || bus.wake)) begin
            state_d = FETCH;
            wake_d  = 1'b0;
          end
        end
        default: begin
          state_d = FETCH;
          step_d  = STEP_FIRST;
          count_d = '0;
        end
      endcase
      if (latch) ir_d = bus.bus_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FETCH;
      step_q         <= STEP_FIRST;
      step_out_q     <= STEP_FIRST;
      count_q        <= '0;
      ir_q           <= '0;
      overrun_q      <= 1'b0;
      wake_q         <= 1'b0;
      instr_start_q  <= 1'b0;
      fetch_active_q <= 1'b1;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      step_out_q     <= (state_d == HALT) ? '0 : step_d;
      count_q        <= count_d;
      ir_q           <= ir_d;
      overrun_q      <= overrun_d;
      wake_q         <= wake_d;
      instr_start_q  <= latch;
      fetch_active_q <= (state_d == FETCH);
      halted_q       <= (state_d == HALT);
    end
  end

  assign bus.cycle_step   = step_out_q;
  assign bus.cycle_count  = count_q;
  assign bus.ir           = ir_q;
  assign bus.fetch_active = fetch_active_q;
  assign bus.instr_start  = instr_start_q;
  assign bus.halted       = halted_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: instruction starts are checked by a scoreboard monitor,
// state/boundary behaviour by direct checks after each clock.
module tb_cycle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cycle_sequencer_if bus ();

  cycle_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ir;
    logic [7:0] count;
    logic [3:0] step;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step3();
    int n = 0;
    while (bus.cycle_step != 4'b1000 && n < 8) begin
      clk1();
      n++;
    end
    if (bus.cycle_step != 4'b1000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_step3: step %b never reached 1000", bus.cycle_step);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step"},  32'(bus.cycle_step),   32'h1);
    check({tag, "_count"}, 32'(bus.cycle_count),  32'h0);
    check({tag, "_ir"},    32'(bus.ir),           32'h0);
    check({tag, "_fa"},    32'(bus.fetch_active), 32'h1);
    check({tag, "_start"}, 32'(bus.instr_start),  32'h0);
    check({tag, "_halt"},  32'(bus.halted),       32'h0);
    check({tag, "_ovr"},   32'(bus.overrun),      32'h0);
  endtask

  // Scoreboard monitor: every instruction-start pulse must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && bus.instr_start) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected_start: got ir=%0h count=%0h, want no start", bus.ir, bus.cycle_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ir",    32'(bus.ir),           32'(e.ir));
        check("sb_count", 32'(bus.cycle_count),  32'(e.count));
        check("sb_step",  32'(bus.cycle_step),   32'(e.step));
        check("sb_fa",    32'(bus.fetch_active), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.ir_fetch     = 1'b0;
    bus.stall        = 1'b0;
    bus.halt_request = 1'b0;
    bus.wake         = 1'b0;
    bus.bus_data     = 8'h18;

    // Reset state, then first fetch of 0x18.
    clk1();
    clk1();
    check_reset_outputs("rst");
    rst = 1'b0;
    sb.push_back('{ir: 8'h18, count: 8'h01, step: 4'b0001});
    clk1();
    check("first_step", 32'(bus.cycle_step), 32'h2);
    clk1();
    clk1();
    check("fetch_step3", 32'(bus.cycle_step), 32'h8);
    check("fetch_no_ir", 32'(bus.ir), 32'h0);
    clk1();
    check("fetch_ir", 32'(bus.ir), 32'h18);
    check("fetch_fa_off", 32'(bus.fetch_active), 32'h0);
    clk1();
    check("start_one_clk", 32'(bus.instr_start), 32'h0);

    // JR-style: two count shifts, then overlapped fetch of 0x00.
    wait_step3();
    clk1();
    check("jr_count2", 32'(bus.cycle_count), 32'h02);
    wait_step3();
    clk1();
    check("jr_count4", 32'(bus.cycle_count), 32'h04);
    wait_step3();
    bus.ir_fetch = 1'b1;
    bus.bus_data = 8'h00;
    sb.push_back('{ir: 8'h00, count: 8'h01, step: 4'b0001});
    clk1();
    bus.ir_fetch = 1'b0;
    check("jr_count1", 32'(bus.cycle_count), 32'h01);
    check("jr_no_fetch_state", 32'(bus.fetch_active), 32'h0);

    // Fetch request on step[1] only is ignored.
    bus.bus_data = 8'hAA;
    clk1();
    bus.ir_fetch = 1'b1;
    clk1();
    bus.ir_fetch = 1'b0;
    check("step1_ir_hold", 32'(bus.ir), 32'h00);
    wait_step3();
    clk1();
    check("step1_count_shift", 32'(bus.cycle_count), 32'h02);
    check("step1_ir_still", 32'(bus.ir), 32'h00);

    // Count walk to 0x80, wrap, sticky overrun.
    for (int i = 2; i < 8; i++) begin
      wait_step3();
      clk1();
      check("walk_count", 32'(bus.cycle_count), 32'(1) << i);
    end
    check("pre_wrap_ovr", 32'(bus.overrun), 32'h0);
    wait_step3();
    clk1();
    check("wrap_count", 32'(bus.cycle_count), 32'h01);
    check("wrap_ovr", 32'(bus.overrun), 32'h1);
    check("wrap_ir", 32'(bus.ir), 32'h00);
    wait_step3();
    clk1();
    check("ovr_sticky", 32'(bus.overrun), 32'h1);
    check("post_wrap_count", 32'(bus.cycle_count), 32'h02);

    // HALT entry, wake at internal step[1].
    wait_step3();
    bus.ir_fetch     = 1'b1;
    bus.halt_request = 1'b1;
    bus.bus_data     = 8'h55;
    clk1();
    bus.ir_fetch     = 1'b0;
    bus.halt_request = 1'b0;
    check("halt_flag", 32'(bus.halted), 32'h1);
    check("halt_step", 32'(bus.cycle_step), 32'h0);
    check("halt_count", 32'(bus.cycle_count), 32'h0);
    check("halt_ir", 32'(bus.ir), 32'h00);
    clk1();
    bus.wake = 1'b1;
    clk1();
    bus.wake = 1'b0;
    check("wake_pending_halted", 32'(bus.halted), 32'h1);
    clk1();
    check("wake_step3_halted", 32'(bus.halted), 32'h1);
    clk1();
    check("wake_fetch_fa", 32'(bus.fetch_active), 32'h1);
    check("wake_halt_off", 32'(bus.halted), 32'h0);
    check("wake_step", 32'(bus.cycle_step), 32'h1);
    check("wake_count", 32'(bus.cycle_count), 32'h0);

    // Stall at FETCH step[3] for 3 clocks.
    bus.bus_data = 8'h3C;
    clk1();
    clk1();
    clk1();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk1();
      check("stall_step", 32'(bus.cycle_step), 32'h8);
      check("stall_ir", 32'(bus.ir), 32'h00);
      check("stall_fa", 32'(bus.fetch_active), 32'h1);
    end
    bus.stall = 1'b0;
    sb.push_back('{ir: 8'h3C, count: 8'h01, step: 4'b0001});
    clk1();
    check("post_stall_ir", 32'(bus.ir), 32'h3C);

    // Asynchronous reset mid-EXEC.
    clk1();
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");

    // Reset in HALT with a pending wake must discard the wake.
    clk1();
    rst = 1'b0;
    bus.bus_data = 8'h42;
    sb.push_back('{ir: 8'h42, count: 8'h01, step: 4'b0001});
    wait_step3();
    clk1();
    wait_step3();
    bus.ir_fetch     = 1'b1;
    bus.halt_request = 1'b1;
    clk1();
    bus.ir_fetch     = 1'b0;
    bus.halt_request = 1'b0;
    clk1();
    bus.wake = 1'b1;
    clk1();
    bus.wake = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("halt_rst_halted", 32'(bus.halted), 32'h0);
    #1;
    rst = 1'b0;
    bus.bus_data = 8'h24;
    sb.push_back('{ir: 8'h24, count: 8'h01, step: 4'b0001});
    wait_step3();
    clk1();
    wait_step3();
    bus.ir_fetch     = 1'b1;
    bus.halt_request = 1'b1;
    clk1();
    bus.ir_fetch     = 1'b0;
    bus.halt_request = 1'b0;
    repeat (4) clk1();
    check("no_stale_wake", 32'(bus.halted), 32'h1);
    check("no_stale_wake_ir", 32'(bus.ir), 32'h24);
    bus.wake = 1'b1;
    clk1();
    bus.wake = 1'b0;
    clk1();
    clk1();
    check("late_wake_halted", 32'(bus.halted), 32'h1);
    clk1();
    check("late_wake_fetch", 32'(bus.fetch_active), 32'h1);

    repeat (2) clk1();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have parameter STEPS, default 4, meaning the T-states per M-cycle; only 4 is supported.
REQ-002 SHALL have parameter MAX_CYCLES, default 8, meaning the one-hot M-cycle count width.
REQ-003 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset.
REQ-005 i_IR_Fetch  input  1  OR of all microcode IR-fetch requests; sampled only on step[3].
REQ-006 i_Stall  input  1  memory wait; freezes all sequencer state for that clock.
REQ-007 i_Halt_Request  input  1  HALT opcode executing; sampled with i_IR_Fetch.
REQ-008 i_Wake  input  1  interrupt pending; ends HALT.
REQ-009 i_Bus_Data  input  8  data bus, latched into IR on a fetch.
REQ-010 o_Cycle_Step  output  4  one-hot T-state to microcode; 0 in HALT.
REQ-011 o_Cycle_Count  output  8  one-hot M-cycle index within instruction; 0 in FETCH and HALT.
REQ-012 o_IR  output  8  current opcode.
REQ-013 o_Fetch_Active  output  1  high throughout the FETCH state.
REQ-014 o_Instr_Start  output  1  one-clock pulse on the first clock of a new instruction.
REQ-015 o_Halted  output  1  high in HALT.
REQ-016 o_Overrun  output  1  sticky error: count wrapped without a fetch.

Function
REQ-017 States SHALL be FETCH, EXEC and HALT.
REQ-018 In FETCH and EXEC, step SHALL rotate 0001->0010->0100->1000->0001, one position per clock, unless stalled.
REQ-019 FETCH SHALL hold count=0x00 and o_Fetch_Active=1, and at step[3] SHALL latch i_Bus_Data into o_IR.
REQ-020 On that FETCH step[3] clock the sequencer SHALL move to EXEC with count=0x01 and step=0001.
REQ-021 In EXEC at step[3] with i_IR_Fetch=1 and i_Halt_Request=0 (overlapped fetch), the sequencer SHALL latch i_Bus_Data into o_IR, set count=0x01, step=0001, and remain in EXEC.
REQ-022 In EXEC at step[3] with i_IR_Fetch=0, count SHALL shift left by one bit.
REQ-023 In EXEC at step[3] with count=0x80 and i_IR_Fetch=0, count SHALL wrap to 0x01, o_Overrun SHALL set, and o_IR SHALL be unchanged.
REQ-024 i_IR_Fetch SHALL be ignored on steps 0-2.
REQ-025 o_Instr_Start SHALL be 1 exactly on the clock after any IR latch.
REQ-026 In EXEC at step[3] with i_IR_Fetch=1 and i_Halt_Request=1, the sequencer SHALL enter HALT without latching IR.
REQ-027 In HALT, outputs SHALL be step=0000, count=0x00 and o_Halted=1, and o_IR SHALL hold.
REQ-028 In HALT, the internal step SHALL keep rotating so that M-cycle timing is kept.
REQ-029 i_Wake=1 in HALT at internal step[3] SHALL move the sequencer to FETCH with step=0001; i_Wake on other steps SHALL be held pending until step[3].
REQ-030 i_Stall=1 SHALL hold state, step, count, o_IR and the pending wake unchanged for that clock.
REQ-031 i_Stall=1 SHALL suppress any IR latch and o_Instr_Start for that clock, in every state including HALT.
REQ-032 Priority SHALL be: reset > stall > halt/wake > fetch > count advance.
REQ-033 Every output SHALL come directly from a register; there SHALL be no combinational path from any input to any output.

Reset
REQ-034 While i_Reset=1, outputs SHALL immediately be: state FETCH, o_Cycle_Step=0001, o_Cycle_Count=0x00, o_IR=0x00, o_Fetch_Active=1, o_Instr_Start=0, o_Halted=0, o_Overrun=0.
REQ-035 Reset asserted mid-instruction or in HALT SHALL discard all progress; the pending wake SHALL be cleared.
REQ-036 The first clock after reset deassertion SHALL advance step to 0010.

Verification
REQ-037 Release reset with bus=0x18 -> after 4 clocks o_IR=0x18, count=0x01, step=0001, o_Instr_Start=1 for one clock.
REQ-038 JR-style sequence: i_IR_Fetch=0 at count 0x01 and 0x02, then 1 at count 0x04 step[3] with bus=0x00 -> count=0x01, o_IR=0x00, no FETCH state visited.
REQ-039 i_IR_Fetch=1 on step[1] only -> no IR change; count still shifts at step[3].
REQ-040 Hold i_IR_Fetch=0 for 8 M-cycles -> count walks 0x01..0x80, wraps to 0x01, o_Overrun=1 and stays set.
REQ-041 i_Halt_Request=1 with i_IR_Fetch=1 at step[3] -> o_Halted=1 and step/count=0; i_Wake at internal step[1] -> FETCH entered 2 clocks later.
REQ-042 i_Stall=1 for 3 clocks at step[3] of FETCH -> no latch during the stall; latch and o_Instr_Start occur after i_Stall drops.
REQ-043 Assert i_Reset asynchronously mid-EXEC -> all outputs reach their reset values before the next clock edge.
